// File: rtl/game_round_controller.sv
// Round controller for the "can you count binary" game: draws an LFSR
// target, judges submitted guesses, keeps a score, feeds the 7-seg stage.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      synchronous active-high reset
//   start    level; rising edge starts a game from IDLE
//   submit   level; rising edge submits guess while in PLAY
//   guess    8-bit switch value entered by the player
//   value    number to render: score in IDLE, target otherwise
//   led_ok   high while showing correct-answer feedback
//   led_bad  high while showing wrong-answer feedback
//   playing  high while waiting for the player's guess
module game_round_controller #(
  parameter logic [23:0] FEEDBACK_CYCLES = 24'd12_000_000,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       submit,
  input  logic [7:0] guess,
  output logic [7:0] value,
  output logic       led_ok,
  output logic       led_bad,
  output logic       playing
);

  localparam int TW = $clog2(int'(FEEDBACK_CYCLES) + 1);
  localparam logic [TW-1:0] TLAST =
    TW'(FEEDBACK_CYCLES - 24'd1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OK,
    S_BAD
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    target_q, target_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic          start_q, submit_q;

  logic start_p;
  logic submit_p;
  logic hit;
  logic expired;

  // Pulses act on the very edge the level is first seen high.
  assign start_p  = start & ~start_q;
  assign submit_p = submit & ~submit_q;
  assign hit      = (guess == target_q);
  assign expired  = (timer_q == TLAST);

  // x^8+x^6+x^5+x^4+1, shifting left; never reaches zero.
  assign lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^
                   lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      score_q  <= 8'd0;
      target_q <= 8'd0;
      timer_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      start_q  <= 1'b0;
      submit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      target_q <= target_d;
      timer_q  <= timer_d;
      lfsr_q   <= lfsr_d;
      start_q  <= start;
      submit_q <= submit;
    end
  end

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    target_d = target_q;
    timer_d  = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          state_d  = S_PLAY;
          score_d  = 8'd0;
          target_d = lfsr_q;
        end
      end
      S_PLAY: begin
        if (submit_p) begin
          timer_d = '0;
          if (hit) begin
            state_d = S_OK;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else begin
            state_d = S_BAD;
          end
        end
      end
      S_OK: begin
        timer_d = timer_q + TW'(1);
        if (expired) begin
          state_d  = S_PLAY;
          target_d = lfsr_q;
        end
      end
      S_BAD: begin
        timer_d = timer_q + TW'(1);
        if (expired) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    value   = target_q;
    led_ok  = 1'b0;
    led_bad = 1'b0;
    playing = 1'b0;
    unique case (state_q)
      S_IDLE: value   = score_q;
      S_PLAY: playing = 1'b1;
      S_OK:   led_ok  = 1'b1;
      S_BAD:  led_bad = 1'b1;
      default: value  = score_q;
    endcase
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Self-checking bench for game_round_controller with a
// behavioural game model and randomized play.
module tb_game_round_controller;

  localparam int FB = 4;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       submit = 1'b0;
  logic [7:0] guess = 8'd0;
  logic [7:0] value;
  logic       led_ok, led_bad, playing;

  int n_cmp = 0;
  int n_bad = 0;

  game_round_controller #(
    .FEEDBACK_CYCLES(24'd4),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .submit(submit),
    .guess(guess),
    .value(value),
    .led_ok(led_ok),
    .led_bad(led_bad),
    .playing(playing)
  );

  always #5 clk = ~clk;

  // Game model: mode 0 idle, 1 play, 2 right, 3 wrong.
  logic [7:0] m_lfsr;
  int         m_mode, m_score, m_left;
  logic [7:0] m_tgt;
  logic       m_ps, m_pb;

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= SEED;
      m_mode <= 0;
      m_score <= 0;
      m_tgt <= 8'd0;
      m_left <= 0;
      m_ps <= 1'b0;
      m_pb <= 1'b0;
    end else begin
      m_lfsr <= nxt(m_lfsr);
      m_ps <= start;
      m_pb <= submit;
      case (m_mode)
        0: if (start && !m_ps) begin
          m_mode <= 1;
          m_score <= 0;
          m_tgt <= m_lfsr;
        end
        1: if (submit && !m_pb) begin
          m_left <= FB;
          if (guess == m_tgt) begin
            m_mode <= 2;
            m_score <= (m_score >= 255) ? 255 : m_score + 1;
          end else begin
            m_mode <= 3;
          end
        end
        default: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_mode <= (m_mode == 2) ? 1 : 0;
            if (m_mode == 2) m_tgt <= m_lfsr;
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] exp_value();
    return (m_mode == 0) ? 8'(m_score) : m_tgt;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    submit = 1'b0;
    guess = 8'd0;
    repeat (3) tick();
    n_cmp++;
    if (value !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_value got %h want 00", value);
    end
    n_cmp++;
    if (led_ok !== 1'b0 || led_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_leds got %b%b want 00", led_ok, led_bad);
    end
    n_cmp++;
    if (playing !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_playing got %b want 0", playing);
    end
  endtask

  task automatic test_start_hold();
    rst = 1'b0;
    start = 1'b1;
    tick();
    n_cmp++;
    if (playing !== 1'b1 || value !== 8'hA5) begin
      n_bad++;
      $display("FAIL start_first got p=%b v=%h want p=1 v=a5",
               playing, value);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if (playing !== 1'b1 || value !== 8'hA5) begin
        n_bad++;
        $display("FAIL start_held got p=%b v=%h want p=1 v=a5",
                 playing, value);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_correct();
    int c;
    guess = m_tgt;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    c = 0;
    while (led_ok === 1'b1 && c < 10) begin
      c++;
      tick();
    end
    n_cmp++;
    if (c != FB) begin
      n_bad++;
      $display("FAIL ok_len got %0d want %0d", c, FB);
    end
    n_cmp++;
    if (playing !== 1'b1 || value !== exp_value()) begin
      n_bad++;
      $display("FAIL ok_return got p=%b v=%h want p=1 v=%h",
               playing, value, exp_value());
    end
  endtask

  task automatic test_wrong();
    int c;
    test_correct();
    test_correct();
    guess = m_tgt ^ 8'h01;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    c = 0;
    while (led_bad === 1'b1 && c < 10) begin
      c++;
      tick();
    end
    n_cmp++;
    if (c != FB) begin
      n_bad++;
      $display("FAIL bad_len got %0d want %0d", c, FB);
    end
    n_cmp++;
    if (playing !== 1'b0 || value !== 8'd3) begin
      n_bad++;
      $display("FAIL bad_idle got p=%b v=%h want p=0 v=03",
               playing, value);
    end
  endtask

  task automatic test_simul();
    guess = 8'($urandom);
    start = 1'b1;
    submit = 1'b1;
    tick();
    n_cmp++;
    if (playing !== 1'b1 || led_ok !== 1'b0 || led_bad !== 1'b0) begin
      n_bad++;
      $display("FAIL simul got p=%b ok=%b bad=%b want 1 0 0",
               playing, led_ok, led_bad);
    end
    tick();
    n_cmp++;
    if (playing !== 1'b1 || value !== exp_value()) begin
      n_bad++;
      $display("FAIL simul_hold got p=%b v=%h want p=1 v=%h",
               playing, value, exp_value());
    end
    start = 1'b0;
    submit = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    guess = m_tgt;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    n_cmp++;
    if (led_ok !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_pre got ok=%b want 1", led_ok);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (value !== 8'd0 || led_ok !== 1'b0 || playing !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst got v=%h ok=%b p=%b want 00 0 0",
               value, led_ok, playing);
    end
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (playing !== 1'b1 || value !== 8'hA5) begin
      n_bad++;
      $display("FAIL mid_seed got p=%b v=%h want p=1 v=a5",
               playing, value);
    end
    tick();
  endtask

  task automatic test_saturate();
    int w;
    bit to;
    to = 1'b0;
    for (int r = 0; r < 257 && !to; r++) begin
      guess = m_tgt;
      submit = 1'b1;
      tick();
      submit = 1'b0;
      w = 0;
      while (playing !== 1'b1 && w < 20) begin
        w++;
        tick();
      end
      if (w >= 20) to = 1'b1;
    end
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL sat_timeout got no return to play want play");
    end
    guess = m_tgt ^ 8'h80;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    w = 0;
    while (playing !== 1'b0 || led_bad !== 1'b0) begin
      if (w >= 20) break;
      w++;
      tick();
    end
    n_cmp++;
    if (value !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_score got %0d want 255", value);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) start = ~start;
      if ($urandom_range(0, 2) == 0) submit = ~submit;
      guess = ($urandom_range(0, 1) == 1) ? m_tgt : 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      n_cmp++;
      if (value !== exp_value()) begin
        n_bad++;
        $display("FAIL rnd_value cyc %0d got %h want %h",
                 i, value, exp_value());
      end
      n_cmp++;
      if (led_ok !== (m_mode == 2) || led_bad !== (m_mode == 3)) begin
        n_bad++;
        $display("FAIL rnd_leds cyc %0d got %b%b want mode %0d",
                 i, led_ok, led_bad, m_mode);
      end
      n_cmp++;
      if (playing !== (m_mode == 1)) begin
        n_bad++;
        $display("FAIL rnd_playing cyc %0d got %b want %b",
                 i, playing, m_mode == 1);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_start_hold();
    test_correct();
    test_wrong();
    test_simul();
    test_reset_mid();
    test_reset();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
